// File: rtl/data_mem_responder.sv
// Word-organised data memory answering the core's load/store request handshake.
// Optional define DMEM_ALIGN_CHECK_EN turns misaligned/illegal-size accesses into faults (err).
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = 4;
  localparam int unsigned IW    = ADDR_WIDTH + 2;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be within 1..15");
  end

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            lat_we, lat_we_nxt;
  logic [IW-1:0]   lat_addr, lat_addr_nxt;
  logic [2:0]      lat_size, lat_size_nxt;
  logic [31:0]     lat_wdata, lat_wdata_nxt;
  logic            ack_nxt, err_nxt;
  logic [31:0]     rdata_nxt;
  logic            commit;

  logic [31:0]     mem [DEPTH];

  // Address bits above the memory depth alias and are deliberately dropped.
  logic            unused_addr;
  assign unused_addr = ^addr[31:IW];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]      lane, off;
  logic            is_byte, is_half, is_signed, fault;
  logic [31:0]     cur_word, shifted, load_val, store_val;
  logic [3:0]      store_mask;

  // Decode the latched request into lane offset, load value, store lanes and fault.
  always_comb begin
    word_idx  = lat_addr[IW-1:2];
    lane      = lat_addr[1:0];
    is_byte   = (lat_size[1:0] == 2'd0);
    is_half   = (lat_size[1:0] == 2'd1);
    is_signed = ~lat_size[2];
    fault     = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    if (lat_size == 3'd3 || lat_size[2:1] == 2'b11) fault = 1'b1;
    if (lat_we && lat_size[2])                      fault = 1'b1;
    if (is_half && lane[0])                         fault = 1'b1;
    if (!is_byte && !is_half && lane != 2'd0)       fault = 1'b1;
`endif
    // Without the check, H/W are forced to natural alignment by the offset choice.
    off       = is_byte ? lane : (is_half ? {lane[1], 1'b0} : 2'd0);
    cur_word  = mem[word_idx];
    shifted   = cur_word >> {off, 3'b000};
    if (is_byte)      load_val = {{24{is_signed & shifted[7]}}, shifted[7:0]};
    else if (is_half) load_val = {{16{is_signed & shifted[15]}}, shifted[15:0]};
    else              load_val = shifted;
    store_val = lat_wdata << {off, 3'b000};
    if (is_byte)      store_mask = 4'b0001 << off;
    else if (is_half) store_mask = 4'b0011 << off;
    else              store_mask = 4'b1111;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    lat_we_nxt    = lat_we;
    lat_addr_nxt  = lat_addr;
    lat_size_nxt  = lat_size;
    lat_wdata_nxt = lat_wdata;
    ack_nxt       = ack;
    err_nxt       = err;
    rdata_nxt     = rdata;
    commit        = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          lat_we_nxt    = we;
          lat_addr_nxt  = addr[IW-1:0];
          lat_size_nxt  = size;
          lat_wdata_nxt = wdata;
          cnt_nxt       = CW'(LATENCY - 1);
          state_nxt     = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_nxt = ACK;
          ack_nxt   = 1'b1;
          err_nxt   = fault;
          rdata_nxt = (fault || lat_we) ? 32'd0 : load_val;
          commit    = lat_we & ~fault;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ACK: begin
        if (!req) begin
          state_nxt = IDLE;
          ack_nxt   = 1'b0;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_size  <= '0;
      lat_wdata <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lat_we    <= lat_we_nxt;
      lat_addr  <= lat_addr_nxt;
      lat_size  <= lat_size_nxt;
      lat_wdata <= lat_wdata_nxt;
      ack       <= ack_nxt;
      err       <= err_nxt;
      rdata     <= rdata_nxt;
    end
  end

  // Storage is not reset; only the addressed byte lanes are written.
  always_ff @(posedge clk) begin
    if (commit) begin
      if (store_mask[0]) mem[word_idx][7:0]   <= store_val[7:0];
      if (store_mask[1]) mem[word_idx][15:8]  <= store_val[15:8];
      if (store_mask[2]) mem[word_idx][23:16] <= store_val[23:16];
      if (store_mask[3]) mem[word_idx][31:24] <= store_val[31:24];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench for data_mem_responder: two instances (LATENCY 2 and 1) against a byte-array model.
`timescale 1ns/1ps
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [2:0]  size;
  logic [31:0] wdata;
  logic        req0, req1;
  logic        ack0, ack1;
  logic        err0, err1;
  logic [31:0] rdata0, rdata1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] model_mem [2][4096];

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .addr(addr), .size(size),
    .wdata(wdata), .ack(ack0), .rdata(rdata0), .err(err0)
  );

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(reset), .req(req1), .we(we), .addr(addr), .size(size),
    .wdata(wdata), .ack(ack1), .rdata(rdata1), .err(err1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic cur_ack(input int sel);
    return sel != 0 ? ack1 : ack0;
  endfunction

  function automatic logic cur_err(input int sel);
    return sel != 0 ? err1 : err0;
  endfunction

  function automatic logic [31:0] cur_rdata(input int sel);
    return sel != 0 ? rdata1 : rdata0;
  endfunction

  task automatic set_req(input int sel, input logic v);
    if (sel != 0) req1 = v;
    else          req0 = v;
  endtask

  // Reference: byte-addressed memory, sizes as byte counts, alignment by rounding down.
  function automatic void ref_access(input int sel, input bit w, input logic [31:0] a,
                                     input logic [2:0] sz, input logic [31:0] d,
                                     output bit e, output logic [31:0] r);
    int nbytes;
    int base;
    bit sgn;
    e = 1'b0;
    r = 32'd0;
    case (sz)
      3'd0, 3'd4: nbytes = 1;
      3'd1, 3'd5: nbytes = 2;
      default:    nbytes = 4;
    endcase
    sgn = (sz == 3'd0) || (sz == 3'd1);
`ifdef DMEM_ALIGN_CHECK_EN
    if (sz == 3'd3 || sz == 3'd6 || sz == 3'd7) e = 1'b1;
    if (w && (sz == 3'd4 || sz == 3'd5))        e = 1'b1;
    if ((int'(a[11:0]) % nbytes) != 0)          e = 1'b1;
    if (e) return;
`endif
    base = int'(a[11:0]) - (int'(a[11:0]) % nbytes);
    if (w) begin
      for (int i = 0; i < nbytes; i++) model_mem[sel][base + i] = d[8*i +: 8];
    end else begin
      for (int i = 0; i < nbytes; i++) r[8*i +: 8] = model_mem[sel][base + i];
      if (sgn && r[8*nbytes-1]) begin
        for (int i = nbytes; i < 4; i++) r[8*i +: 8] = 8'hFF;
      end
    end
  endfunction

  // One complete handshake; early=1 drops req right after acceptance.
  task automatic txn(input int sel, input bit w, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] d, input int hold, input bit early,
                     output logic [31:0] rd_o, output logic err_o);
    int  n;
    int  lat;
    bit  e;
    logic [31:0] r;
    lat = (sel != 0) ? 1 : 2;
    ref_access(sel, w, a, sz, d, e, r);
    @(negedge clk);
    we = w; addr = a; size = sz; wdata = d;
    set_req(sel, 1'b1);
    @(posedge clk); #1;
    n = 1;
    if (early) begin
      @(negedge clk);
      set_req(sel, 1'b0);
    end
    while (!cur_ack(sel) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ack_latency", 32'(n), 32'(lat + 1));
    rd_o  = cur_rdata(sel);
    err_o = cur_err(sel);
    check("err", {31'd0, err_o}, {31'd0, e});
    if (!w || e) check("rdata", rd_o, r);
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("ack_hold", {31'd0, cur_ack(sel)}, 32'd1);
      end
      @(negedge clk);
      set_req(sel, 1'b0);
    end
    @(posedge clk); #1;
    check("ack_fall", {31'd0, cur_ack(sel)}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    int          sel;

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    we = 1'b0; addr = '0; size = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_ack0", {31'd0, ack0}, 32'd0);
    check("rst_err0", {31'd0, err0}, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_ack1", {31'd0, ack1}, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);

    for (int s = 0; s < 2; s++)
      for (int wi = 0; wi < 64; wi++)
        txn(s, 1'b1, 32'(wi * 4), 3'd2, $urandom(), 0, 1'b0, rd, er);

    txn(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 1'b0, rd, er);
    check("plan_stw_err", {31'd0, er}, 32'd0);
    txn(0, 1'b0, 32'h10, 3'd2, 32'h0, 0, 1'b0, rd, er);
    check("plan_ldw", rd, 32'hDEADBEEF);
    txn(0, 1'b0, 32'h11, 3'd0, 32'h0, 0, 1'b0, rd, er);
    check("plan_ldb", rd, 32'hFFFFFFBE);
    txn(0, 1'b0, 32'h11, 3'd4, 32'h0, 0, 1'b0, rd, er);
    check("plan_ldbu", rd, 32'h000000BE);
    txn(0, 1'b0, 32'h12, 3'd1, 32'h0, 0, 1'b0, rd, er);
    check("plan_ldh", rd, 32'hFFFFDEAD);
    txn(0, 1'b0, 32'h12, 3'd5, 32'h0, 0, 1'b0, rd, er);
    check("plan_ldhu", rd, 32'h0000DEAD);
    txn(0, 1'b1, 32'h13, 3'd0, 32'h00000055, 0, 1'b0, rd, er);
    txn(0, 1'b0, 32'h10, 3'd2, 32'h0, 0, 1'b0, rd, er);
    check("plan_stb_lanes", rd, 32'h55ADBEEF);

    txn(0, 1'b1, 32'h12, 3'd2, 32'hCAFEF00D, 0, 1'b0, rd, er);
    txn(0, 1'b0, 32'h10, 3'd2, 32'h0, 0, 1'b0, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    check("plan_misaligned_kept", rd, 32'h55ADBEEF);
`else
    check("plan_misaligned_forced", rd, 32'hCAFEF00D);
`endif

    // Reset while a store is still in flight must drop it.
    @(negedge clk);
    we = 1'b1; addr = 32'h20; size = 3'd2; wdata = 32'h12345678; req0 = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst_ack", {31'd0, ack0}, 32'd0);
    check("midrst_err", {31'd0, err0}, 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_ack_after", {31'd0, ack0}, 32'd0);
    txn(0, 1'b0, 32'h20, 3'd2, 32'h0, 0, 1'b0, rd, er);
    check("midrst_not_committed", {31'd0, rd == 32'h12345678}, 32'd0);

    txn(0, 1'b0, 32'h10, 3'd2, 32'h0, 5, 1'b0, rd, er);
    txn(1, 1'b0, 32'h14, 3'd2, 32'h0, 5, 1'b0, rd, er);
    txn(0, 1'b0, 32'h18, 3'd1, 32'h0, 0, 1'b1, rd, er);
    txn(1, 1'b1, 32'h1C, 3'd0, 32'h000000A5, 0, 1'b1, rd, er);

    for (int k = 0; k < 300; k++) begin
      sel = int'($urandom_range(1, 0));
      a = $urandom();
      a[11:2] = 10'($urandom_range(63, 0));
      txn(sel, 1'($urandom_range(1, 0)), a, 3'($urandom_range(7, 0)), $urandom(),
          int'($urandom_range(2, 0)), ($urandom_range(7, 0) == 0), rd, er);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
